// File: rtl/pc_gen_pkg.sv
// Shared types and default vectors for the program-counter generator.
// The build macro PC_GEN_RAS_EN (see pc_gen.sv) does not change this package.
package pc_gen_pkg;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_STALL
  } pc_state_e;

  typedef enum logic [2:0] {
    SRC_HOLD,
    SRC_INC,
    SRC_TRAP,
    SRC_EPC,
    SRC_RAS,
    SRC_TGT
  } pc_src_e;

  localparam logic [31:0] DEF_RESET_VEC = 32'h0040_0000;
  localparam logic [31:0] DEF_TRAP_VEC  = 32'h0040_0004;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
// Storage is not reset, only the pointer and occupancy count.
module pc_ras
  import pc_gen_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top,
  output logic              empty,
  output logic              full
);

  localparam int PTR_W = (RAS_DEPTH > 2) ? $clog2(RAS_DEPTH) : 1;

  logic [ADDR_W-1:0] mem [RAS_DEPTH];
  logic [PTR_W-1:0]  sp_q;
  logic [PTR_W:0]    cnt_q;
  logic [PTR_W-1:0]  sp_inc;

  assign sp_inc = sp_q + PTR_W'(1);
  assign top    = mem[sp_q];
  assign empty  = (cnt_q == '0);
  assign full   = (cnt_q == (PTR_W + 1)'(RAS_DEPTH));

  always_ff @(negedge clk or posedge rst_n) begin
    if (rst_n) begin
      sp_q  <= '0;
      cnt_q <= '0;
    end else if (push) begin
      sp_q <= sp_inc;
      if (!full) cnt_q <= cnt_q + (PTR_W + 1)'(1);
    end else if (pop && !empty) begin
      sp_q  <= sp_q - PTR_W'(1);
      cnt_q <= cnt_q - (PTR_W + 1)'(1);
    end
  end

  always_ff @(negedge clk) begin
    if (push) mem[sp_inc] <= push_data;
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: boot/run/stall FSM, trap/eret, redirects, falling-edge state.
// Define PC_GEN_RAS_EN to build in the return-address stack and call/ret handling.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(DEF_RESET_VEC),
  parameter logic [ADDR_W-1:0] TRAP_VEC  = ADDR_W'(DEF_TRAP_VEC),
  parameter int                RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  input  logic              trap,
  input  logic              eret,
  input  logic              call,
  input  logic              ret,
  output logic [ADDR_W-1:0] pc,
  output logic              pc_valid,
  output logic [ADDR_W-1:0] epc,
  output logic              misalign,
  output logic              ras_empty,
  output logic              ras_full
);

  function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:2], 2'b00};
  endfunction

  pc_state_e         state_q, state_d;
  pc_src_e           src;
  logic              mis_set;
  logic              mis_q;
  logic [ADDR_W-1:0] pc_q, pc_d, epc_q;
  logic [ADDR_W-1:0] pc_inc;
  logic              ras_empty_w, ras_full_w;

  assign pc_inc = pc_q + ADDR_W'(4);

`ifdef PC_GEN_RAS_EN
  logic              ras_push, ras_pop;
  logic [ADDR_W-1:0] ras_top;

  pc_ras #(
    .ADDR_W   (ADDR_W),
    .RAS_DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (ras_push & ena),
    .pop      (ras_pop & ena),
    .push_data(pc_inc),
    .top      (ras_top),
    .empty    (ras_empty_w),
    .full     (ras_full_w)
  );
`else
  // Hint inputs and depth have no effect without the stack.
  logic unused_cfg;
  assign unused_cfg  = call ^ ret ^ (RAS_DEPTH < 2);
  assign ras_empty_w = 1'b1;
  assign ras_full_w  = 1'b0;
`endif

  always_ff @(negedge clk or posedge rst_n) begin
    if (rst_n) state_q <= ST_BOOT;
    else if (ena) state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN, ST_STALL: begin
        if (trap)       state_d = ST_RUN;
        else if (stall) state_d = ST_STALL;
        else            state_d = ST_RUN;
      end
      default: state_d = ST_BOOT;
    endcase
  end

  // Trap wins even while stalled; stall and trap both block any stack traffic.
  always_comb begin
    src      = SRC_HOLD;
    mis_set  = 1'b0;
    pc_valid = (state_q != ST_BOOT);
`ifdef PC_GEN_RAS_EN
    ras_push = 1'b0;
    ras_pop  = 1'b0;
`endif
    if (state_q != ST_BOOT) begin
      if (trap) begin
        src = SRC_TRAP;
      end else if (stall) begin
        src = SRC_HOLD;
      end else if (eret) begin
        src = SRC_EPC;
`ifdef PC_GEN_RAS_EN
      end else if (ret && !ras_empty_w) begin
        src     = SRC_RAS;
        ras_pop = 1'b1;
      end else if (redirect_valid) begin
        src      = SRC_TGT;
        mis_set  = |redirect_target[1:0];
        ras_push = call && !ret;
`else
      end else if (redirect_valid) begin
        src     = SRC_TGT;
        mis_set = |redirect_target[1:0];
`endif
      end else begin
        src = SRC_INC;
      end
    end
  end

  always_comb begin
    pc_d = pc_q;
    case (src)
      SRC_INC:  pc_d = pc_inc;
      SRC_TRAP: pc_d = TRAP_VEC;
      SRC_EPC:  pc_d = epc_q;
      SRC_TGT:  pc_d = align_word(redirect_target);
`ifdef PC_GEN_RAS_EN
      SRC_RAS:  pc_d = ras_top;
`endif
      default:  pc_d = pc_q;
    endcase
  end

  always_ff @(negedge clk or posedge rst_n) begin
    if (rst_n) begin
      pc_q  <= RESET_VEC;
      epc_q <= '0;
      mis_q <= 1'b0;
    end else if (ena) begin
      pc_q <= pc_d;
      if (src == SRC_TRAP) epc_q <= pc_q;
      if (mis_set) mis_q <= 1'b1;
    end
  end

  assign pc        = pc_q;
  assign epc       = epc_q;
  assign misalign  = mis_q;
  assign ras_empty = ras_empty_w;
  assign ras_full  = ras_full_w;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen with a queue-based reference model checked every cycle.
// Expectations follow the PC_GEN_RAS_EN build setting.
module tb_pc_gen;

`ifdef PC_GEN_RAS_EN
  localparam bit RAS_EN = 1'b1;
`else
  localparam bit RAS_EN = 1'b0;
`endif
  localparam int          RAS_DEPTH = 4;
  localparam logic [31:0] RST_V     = 32'h0040_0000;
  localparam logic [31:0] TRAP_V    = 32'h0040_0004;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b0, stall = 1'b0, redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        trap = 1'b0, eret = 1'b0, call = 1'b0, ret = 1'b0;
  logic [31:0] pc, epc;
  logic        pc_valid, misalign, ras_empty, ras_full;

  pc_gen dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .trap(trap), .eret(eret), .call(call), .ret(ret),
    .pc(pc), .pc_valid(pc_valid), .epc(epc), .misalign(misalign),
    .ras_empty(ras_empty), .ras_full(ras_full)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  logic [31:0] m_pc, m_epc;
  bit          m_valid, m_mis;
  logic [31:0] m_ras[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = RST_V; m_epc = '0; m_valid = 1'b0; m_mis = 1'b0;
    m_ras.delete();
  endtask

  task automatic model_edge(input bit st, input bit tr, input bit er, input bit rv,
                            input logic [31:0] tgt, input bit ca, input bit re);
    if (!m_valid) begin m_valid = 1'b1; return; end
    if (tr) begin m_epc = m_pc; m_pc = TRAP_V; return; end
    if (st) return;
    if (er) begin m_pc = m_epc; return; end
    if (RAS_EN && re && m_ras.size() > 0) begin m_pc = m_ras.pop_back(); return; end
    if (rv) begin
      if (RAS_EN && ca && !re) begin
        if (m_ras.size() == RAS_DEPTH) void'(m_ras.pop_front());
        m_ras.push_back(m_pc + 32'd4);
      end
      if (tgt[1:0] != 2'b00) m_mis = 1'b1;
      m_pc = {tgt[31:2], 2'b00};
      return;
    end
    m_pc = m_pc + 32'd4;
  endtask

  always @(posedge clk) begin
    if (chk_en) begin
      check("pc", pc, m_pc);
      check("pc_valid", {31'b0, pc_valid}, {31'b0, m_valid});
      check("epc", epc, m_epc);
      check("misalign", {31'b0, misalign}, {31'b0, m_mis});
      check("ras_empty", {31'b0, ras_empty}, {31'b0, (RAS_EN ? (m_ras.size() == 0) : 1'b1)});
      check("ras_full", {31'b0, ras_full}, {31'b0, (RAS_EN ? (m_ras.size() == RAS_DEPTH) : 1'b0)});
    end
  end

  task automatic step(input bit e, input bit st, input bit tr, input bit er, input bit rv,
                      input logic [31:0] tgt, input bit ca, input bit re);
    @(posedge clk); #1;
    ena = e; stall = st; trap = tr; eret = er;
    redirect_valid = rv; redirect_target = tgt; call = ca; ret = re;
    @(negedge clk); #1;
    if (e) model_edge(st, tr, er, rv, tgt, ca, re);
  endtask

  task automatic adv();
    step(1, 0, 0, 0, 0, 32'h0, 0, 0);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b1;
    model_reset();
    #1;
    check("rst_pc", pc, RST_V);
    check("rst_valid", {31'b0, pc_valid}, 32'd0);
    check("rst_epc", epc, 32'h0);
    check("rst_mis", {31'b0, misalign}, 32'd0);
    check("rst_empty", {31'b0, ras_empty}, 32'd1);
    check("rst_full", {31'b0, ras_full}, 32'd0);
    ena = 1'b1; trap = 1'b1;
    @(negedge clk); #1;
    check("rst_hold_pc", pc, RST_V);
    ena = 1'b0; trap = 1'b0; stall = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  logic [31:0] exp_ret [4];

  initial begin
    model_reset();
    do_reset();
    chk_en = 1'b1;

    // Boot edge then two increments.
    adv();
    check("boot_pc", pc, 32'h0040_0000);
    check("boot_valid", {31'b0, pc_valid}, 32'd1);
    adv(); check("inc1", pc, 32'h0040_0004);
    adv(); check("inc2", pc, 32'h0040_0008);
    adv(); adv(); check("inc4", pc, 32'h0040_0010);

    // Stall, trap during stall, return.
    step(1, 1, 0, 0, 0, 32'h0, 0, 0);
    check("stall_pc", pc, 32'h0040_0010);
    check("stall_valid", {31'b0, pc_valid}, 32'd1);
    step(1, 1, 1, 0, 0, 32'h0, 0, 0);
    check("trap_pc", pc, 32'h0040_0004);
    check("trap_epc", epc, 32'h0040_0010);
    step(1, 0, 0, 1, 0, 32'h0, 0, 0);
    check("eret_pc", pc, 32'h0040_0010);

    // Disabled edge ignores trap.
    step(0, 0, 1, 0, 0, 32'h0, 0, 0);
    check("ena0_pc", pc, 32'h0040_0010);
    check("ena0_epc", epc, 32'h0040_0010);

    // Misaligned redirect sets the sticky flag.
    step(1, 0, 0, 0, 1, 32'h0040_0123, 0, 0);
    check("redir_pc", pc, 32'h0040_0120);
    check("redir_mis", {31'b0, misalign}, 32'd1);
    adv();
    check("mis_sticky", {31'b0, misalign}, 32'd1);

    // Five calls into a four-deep stack, then five returns.
    for (int i = 1; i <= 5; i++) step(1, 0, 0, 0, 1, 32'h0040_0000 + 32'(i) * 32'h1000, 1, 0);
    check("call5_pc", pc, 32'h0040_5000);
    exp_ret[0] = RAS_EN ? 32'h0040_4004 : 32'h0040_5004;
    exp_ret[1] = RAS_EN ? 32'h0040_3004 : 32'h0040_5008;
    exp_ret[2] = RAS_EN ? 32'h0040_2004 : 32'h0040_500C;
    exp_ret[3] = RAS_EN ? 32'h0040_1004 : 32'h0040_5010;
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 0, 0, 32'h0, 0, 1);
      check("ret_lifo", pc, exp_ret[i]);
    end
    step(1, 0, 0, 0, 0, 32'h0, 0, 1);
    check("ret_empty_pc", pc, RAS_EN ? 32'h0040_1008 : 32'h0040_5014);
    check("ret_empty_flag", {31'b0, ras_empty}, 32'd1);

    // Call without redirect, stack suppression under stall/trap, call+ret together.
    step(1, 0, 0, 0, 0, 32'h0, 1, 0);
    step(1, 0, 0, 0, 1, 32'h0040_6000, 1, 0);
    step(1, 1, 0, 0, 0, 32'h0, 0, 1);
    step(1, 0, 1, 0, 0, 32'h0, 0, 1);
    check("trap_ret_epc", epc, 32'h0040_6000);
    step(1, 0, 0, 1, 0, 32'h0, 0, 0);
    step(1, 0, 0, 0, 0, 32'h0, 0, 1);
    step(1, 0, 0, 0, 1, 32'h0040_7000, 1, 1);
    check("callret_pc", pc, 32'h0040_7000);

    // Increment wraps to zero.
    step(1, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0);
    adv();
    check("wrap_pc", pc, 32'h0000_0000);

    // Reset in the middle of a stall restarts from boot.
    step(1, 1, 0, 0, 0, 32'h0, 0, 0);
    do_reset();
    adv();
    check("reboot_pc", pc, 32'h0040_0000);
    check("reboot_valid", {31'b0, pc_valid}, 32'd1);
    adv();
    check("reboot_inc", pc, 32'h0040_0004);

    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
